// File: rtl/vga_timing_receiver.sv
// rtl/vga_timing_receiver.sv - recovers VGA position, line/frame length and lock from hsync/vsync
module vga_timing_receiver #(
  parameter int H_TOTAL    = 800,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int H_ACTIVE   = 640,
  parameter int V_TOTAL    = 525,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int V_ACTIVE   = 480,
  parameter int LOCK_LINES = 4,
  parameter int CW         = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic [CW-1:0] line_len,
  output logic [CW-1:0] frame_lines,
  output logic          locked,
  output logic          de,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          frame_start
);

  localparam int MW = $clog2(LOCK_LINES + 1);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] H_TOT     = CW'(H_TOTAL);
  localparam logic [CW-1:0] H_TIMEOUT = CW'(2 * H_TOTAL - 1);
  localparam logic [CW-1:0] H_START   = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_END     = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_START   = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_END     = CW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [MW-1:0] LOCK_CNT  = MW'(LOCK_LINES);

  if (H_SYNC + H_BP + H_ACTIVE > H_TOTAL || V_SYNC + V_BP + V_ACTIVE > V_TOTAL) begin : g_bad_timing
    $error("active window does not fit inside the total timing");
  end

  // [0],[1] synchronise the async input, [2] holds the previous synchronised value
  logic [2:0] hs_sync;
  logic [2:0] vs_sync;
  logic       hs_fall;
  logic       vs_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_sync <= 3'b111;
      vs_sync <= 3'b111;
    end else begin
      hs_sync <= {hs_sync[1:0], hsync_in};
      vs_sync <= {vs_sync[1:0], vsync_in};
    end
  end

  assign hs_fall = hs_sync[2] & ~hs_sync[1];
  assign vs_fall = vs_sync[2] & ~vs_sync[1];

  logic [CW-1:0] hcount_inc;
  logic [CW-1:0] vcount_inc;
  logic          line_ok;
  logic          timeout;

  assign hcount_inc = hcount + 1'b1;
  assign vcount_inc = vcount + 1'b1;
  assign line_ok    = (hcount_inc == H_TOT);
  assign timeout    = (hcount == H_TIMEOUT) & ~hs_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount   <= '0;
      line_len <= '0;
    end else if (hs_fall) begin
      hcount   <= '0;
      line_len <= hcount_inc;
    end else if (hcount != CNT_MAX) begin
      hcount <= hcount_inc;
    end
  end

  // A vsync edge only marks the frame; the frame actually starts on the next line edge
  logic pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcount      <= '0;
      frame_lines <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (hs_fall) begin
        if (pending | vs_fall) begin
          vcount      <= '0;
          frame_lines <= vcount_inc;
          pending     <= 1'b0;
          frame_start <= locked;
        end else if (vcount != CNT_MAX) begin
          vcount <= vcount_inc;
        end
      end else if (vs_fall) begin
        pending <= 1'b1;
      end
    end
  end

  logic [1:0]    state;
  logic [MW-1:0] match_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      match_cnt <= '0;
      locked    <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (hs_fall) begin
            state     <= CHECK;
            match_cnt <= '0;
          end
        end
        CHECK: begin
          if (hs_fall) begin
            if (line_ok) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt + 1'b1 == LOCK_CNT) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end else if (timeout) begin
            state <= SEARCH;
          end
        end
        LOCKED: begin
          if ((hs_fall & ~line_ok) | timeout) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  logic h_act;
  logic v_act;
  logic de_next;

  assign h_act   = (hcount >= H_START) && (hcount < H_END);
  assign v_act   = (vcount >= V_START) && (vcount < V_END);
  assign de_next = locked & h_act & v_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de      <= 1'b0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else begin
      de      <= de_next;
      pixel_x <= de_next ? hcount - H_START : '0;
      pixel_y <= de_next ? vcount - V_START : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// tb/tb_vga_timing_receiver.sv - self-checking bench for vga_timing_receiver
module tb_vga_timing_receiver;

  localparam int CW   = 13;
  localparam int HT   = 800;
  localparam int HS   = 96;
  localparam int HB   = 48;
  localparam int HA   = 640;
  localparam int VT   = 12;
  localparam int VS   = 2;
  localparam int VB   = 3;
  localparam int VA   = 5;
  localparam int LL   = 4;
  localparam int MAXC = 8191;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hsync_in = 1'b1;
  logic          vsync_in = 1'b1;
  logic [CW-1:0] hcount, vcount, line_len, frame_lines, pixel_x, pixel_y;
  logic          locked, de, frame_start;

  vga_timing_receiver #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
    .LOCK_LINES(LL), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hcount(hcount), .vcount(vcount), .line_len(line_len), .frame_lines(frame_lines),
    .locked(locked), .de(de), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: positions as elapsed time since detected edges, lock as a run of good lines
  int m_hc, m_vc, m_ll, m_fl, m_px, m_py, run;
  bit m_lk, m_de, m_fs, pend;
  bit hd1, hd2, hd3, vd1, vd2, vd3;

  bit stat_on = 0;
  bit prev_de = 0;
  bit prev_lk = 0;
  int de_run = 0, de_runs = 0, fs_cnt = 0, max_px = 0, max_py = 0, lk_drop_hc = -1;

  typedef struct {
    int len;
    int exp_locked;
    int exp_line_len;
  } row_t;
  row_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_hc = 0; m_vc = 0; m_ll = 0; m_fl = 0; m_px = 0; m_py = 0;
    m_lk = 0; m_de = 0; m_fs = 0; pend = 0; run = -1;
    hd1 = 1; hd2 = 1; hd3 = 1; vd1 = 1; vd2 = 1; vd3 = 1;
  endtask

  task automatic model_step();
    bit fh, fv, ok, olk;
    int ohc, ovc;
    if (rst) begin
      model_clear();
      return;
    end
    // an input edge becomes visible three clocks after it is sampled
    fh = hd3 && !hd2;
    fv = vd3 && !vd2;
    hd3 = hd2; hd2 = hd1; hd1 = hsync_in;
    vd3 = vd2; vd2 = vd1; vd1 = vsync_in;
    ohc = m_hc; ovc = m_vc; olk = m_lk;
    m_de = olk && ohc >= HS + HB && ohc < HS + HB + HA && ovc >= VS + VB && ovc < VS + VB + VA;
    m_px = m_de ? ohc - (HS + HB) : 0;
    m_py = m_de ? ovc - (VS + VB) : 0;
    m_fs = 0;
    if (fh) begin
      m_hc = 0;
      m_ll = (ohc + 1) % (MAXC + 1);
      if (pend || fv) begin
        m_vc = 0;
        m_fl = (ovc + 1) % (MAXC + 1);
        pend = 0;
        m_fs = olk;
      end else begin
        m_vc = (ovc < MAXC) ? ovc + 1 : MAXC;
      end
      ok = ((ohc + 1) == HT);
      if (run < 0) run = 0;
      else if (ok) begin
        if (run < LL) run++;
      end else run = (run >= LL) ? -1 : 0;
    end else begin
      m_hc = (ohc < MAXC) ? ohc + 1 : MAXC;
      if (fv) pend = 1;
      if (run >= 0 && ohc == 2 * HT - 1) run = -1;
    end
    m_lk = (run >= LL);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("hcount", hcount, m_hc);
    check("vcount", vcount, m_vc);
    check("line_len", line_len, m_ll);
    check("frame_lines", frame_lines, m_fl);
    check("locked", locked, m_lk);
    check("de", de, m_de);
    check("pixel_x", pixel_x, m_px);
    check("pixel_y", pixel_y, m_py);
    check("frame_start", frame_start, m_fs);
    if (prev_lk && !locked) lk_drop_hc = hcount;
    prev_lk = locked;
    if (stat_on) begin
      if (de) begin
        if (!prev_de) begin
          check("de_first_hcount", hcount, HS + HB + 1);
          check("de_first_px", pixel_x, 0);
        end
        de_run++;
        if (pixel_x > max_px) max_px = pixel_x;
        if (pixel_y > max_py) max_py = pixel_y;
      end else if (prev_de) begin
        check("de_run_len", de_run, HA);
        de_runs++;
        de_run = 0;
      end
      if (frame_start) fs_cnt++;
    end
    prev_de = de;
  endtask

  task automatic send_line(input int len, input int vs_fall_at, input int vs_rise_at);
    int lo;
    lo = (len / 2 < HS) ? len / 2 : HS;
    for (int i = 0; i < len; i++) begin
      hsync_in = (i < lo) ? 1'b0 : 1'b1;
      if (i == vs_fall_at) vsync_in = 1'b0;
      if (i == vs_rise_at) vsync_in = 1'b1;
      tick();
    end
  endtask

  initial begin
    int len, r, vf, vr;

    tbl[0]  = '{800, 0, -1};
    tbl[1]  = '{800, 0, 800};
    tbl[2]  = '{800, 0, 800};
    tbl[3]  = '{800, 0, 800};
    tbl[4]  = '{800, 1, 800};
    tbl[5]  = '{799, 1, 800};
    tbl[6]  = '{800, 0, 799};
    tbl[7]  = '{800, 0, 800};
    tbl[8]  = '{800, 0, 800};
    tbl[9]  = '{800, 0, 800};
    tbl[10] = '{800, 0, 800};
    tbl[11] = '{800, 1, 800};

    model_clear();
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();

    // lock acquisition, a short line, and relock
    for (int i = 0; i < 12; i++) begin
      send_line(tbl[i].len, -1, -1);
      check("tbl_locked", locked, tbl[i].exp_locked);
      if (tbl[i].exp_line_len >= 0) check("tbl_line_len", line_len, tbl[i].exp_line_len);
    end

    // three nominal frames, vsync falling in the same clock as hsync
    stat_on = 1;
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < VT; l++) begin
        send_line(HT, (l == 0) ? 0 : -1, (l == 2) ? 0 : -1);
        if (l == 0) check("vs_same_clk_vcount", vcount, 0);
      end
    end
    stat_on = 0;
    check("frame_lines", frame_lines, VT);
    check("frame_start_count", fs_cnt, 3);
    check("active_rows", de_runs, 3 * VA);
    check("max_pixel_x", max_px, HA - 1);
    check("max_pixel_y", max_py, VA - 1);

    // vsync falling mid-line is deferred to the next line edge
    send_line(HT, 400, -1);
    check("mid_vs_deferred", vcount, VT);
    send_line(HT, -1, 0);
    check("mid_vs_applied", vcount, 0);
    check("mid_vs_frame_lines", frame_lines, VT + 1);

    // hsync stuck high while locked
    check("pre_timeout_locked", locked, 1);
    lk_drop_hc = -1;
    send_line(8300, -1, -1);
    check("timeout_drop_hcount", lk_drop_hc, 2 * HT);
    check("hcount_saturated", hcount, MAXC);
    check("timeout_unlocked", locked, 0);

    // relock, then asynchronous reset in the middle of a line
    for (int i = 0; i < 6; i++) send_line(HT, -1, -1);
    check("relock_before_rst", locked, 1);
    for (int i = 0; i < 300; i++) begin
      hsync_in = (i < HS) ? 1'b0 : 1'b1;
      tick();
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_line_len", line_len, 0);
    check("rst_frame_lines", frame_lines, 0);
    check("rst_locked", locked, 0);
    check("rst_de", de, 0);
    check("rst_pixel_x", pixel_x, 0);
    check("rst_pixel_y", pixel_y, 0);
    check("rst_frame_start", frame_start, 0);
    model_clear();
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 6; i++) send_line(HT, -1, -1);
    check("relock_after_rst", locked, 1);

    // randomized line lengths and vsync placement
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) len = HT;
      else if (r == 6) len = HT - 1;
      else if (r == 7) len = HT + 1;
      else if (r == 8) len = $urandom_range(20, 900);
      else len = $urandom_range(1000, 1700);
      vf = -1;
      vr = -1;
      if (vsync_in == 1'b0) vr = $urandom_range(0, len - 1);
      else if ($urandom_range(0, 5) < 2) vf = $urandom_range(0, len - 1);
      send_line(len, vf, vr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_receiver.md
Name: vga_timing_receiver

Overview:
Sink-side counterpart to the VGA sync generator. It takes hsync/vsync from an external or looped-back VGA timing source and recovers horizontal and vertical position. It locks to the nominal 800x525 timing, measures line and frame length, and produces pixel_x/pixel_y/de for the capture and self-check logic. It uses the same pixel clock as the generator.

Parameters:
H_TOTAL, 800, pixel clocks per line
H_SYNC, 96, hsync pulse width
H_BP, 48, back porch after hsync pulse
H_ACTIVE, 640, visible pixels per line
V_TOTAL, 525, lines per frame
V_SYNC, 2, vsync pulse lines
V_BP, 33, vertical back porch lines
V_ACTIVE, 480, visible lines
LOCK_LINES, 4, consecutive correct lines required to lock
CW, 13, width of all counters

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
hsync_in  in  1  horizontal sync, active-low, asynchronous to clk
vsync_in  in  1  vertical sync, active-low, asynchronous to clk
hcount  out  CW  pixel clocks since the last hsync falling edge
vcount  out  CW  lines since the last frame start
line_len  out  CW  measured period of the last complete line
frame_lines  out  CW  measured line count of the last complete frame
locked  out  1  timing matches parameters
de  out  1  active-video qualifier
pixel_x  out  CW  active-area column, 0 when de=0
pixel_y  out  CW  active-area row, 0 when de=0
frame_start  out  1  one-cycle pulse at the first line of a frame

Behaviour:
- rst=1 forces all outputs and internal state to 0 immediately; FSM goes to SEARCH. Synchronizer flops reset to 1 (idle-high).
- Each sync input passes through a 2-flop synchronizer plus a history flop. hs_fall = prev 1 and current 0; vs_fall is derived the same way. Input-to-edge latency is 3 clk.
- hcount:
  - On hs_fall, hcount <= 0.
  - Otherwise hcount increments and saturates at 2^CW-1.
- line_len: on hs_fall, line_len <= hcount+1.
- Vertical tracking:
  - vs_fall sets a pending flag.
  - On an hs_fall with pending set (including a vs_fall in the same cycle): vcount <= 0, frame_lines <= vcount+1, pending cleared, and frame_start=1 for that cycle if locked.
  - On any other hs_fall, vcount increments and saturates.
- FSM states:
  - SEARCH: the first hs_fall moves to CHECK with match_cnt=0.
  - CHECK: on each hs_fall, if hcount+1==H_TOTAL then match_cnt++; otherwise match_cnt<=0. When match_cnt reaches LOCK_LINES, go to LOCKED.
  - LOCKED: an hs_fall with hcount+1!=H_TOTAL goes to SEARCH.
  - CHECK or LOCKED: if hcount reaches 2*H_TOTAL-1 with no edge (timeout), go to SEARCH.
  - locked=1 only in LOCKED, registered.
- Active region:
  - h_act when H_SYNC+H_BP <= hcount < H_SYNC+H_BP+H_ACTIVE.
  - v_act when V_SYNC+V_BP <= vcount < V_SYNC+V_BP+V_ACTIVE.
- de, pixel_x and pixel_y are registered, 1 clk after the hcount/vcount values they derive from.
  - de = locked & h_act & v_act.
  - pixel_x = hcount-(H_SYNC+H_BP) when de, else 0.
  - pixel_y = vcount-(V_SYNC+V_BP) when de, else 0.
- Vertical lock is not required: vertical values are reported, and de simply stays 0 until vcount enters the active window.
- Losing lock forces de=0 on the next cycle; counters keep running.

Test Plan:
1. Nominal 800x525 stream → locked rises on the 5th hs_fall after reset release; line_len=800.
2. After the second frame start → frame_lines=525 and frame_start pulses once per frame.
3. Active-line mapping, while locked → de=1 for exactly 640 consecutive clks per active line.
   - pixel_x runs 0..639; the first de is one clk after hcount=144.
4. Active-row count → 480 active rows per frame, pixel_y 0..479.
5. One line of 799 clks while locked → locked=0 after that edge.
   - de=0 from the next clk; relock after 5 further correct edges.
6. hsync held high while locked → locked drops when hcount=1599, and hcount saturates at 8191.
7. vsync and hsync falling in the same clk → vcount=0 on that edge.
   - A vsync falling mid-line instead takes effect only at the next hs_fall.
8. rst pulsed mid-line (between clk edges) → all outputs 0 without waiting for a clk edge.
   - Relock completes normally after release.
